next_pc_ctrl: RTL and testbench

Next-PC controller for the pipelined CPU. Each cycle it computes the fetch address and write enable that drive the PC register's address/write inputs. It arbitrates sequential fetch, ID-stage jumps, EX-stage branch resolution and hazard stalls, and issues the matching IF/ID flushes. It sits between the hazard unit/EX stage and the PC register, the writer side of the PC interface.

---
 rtl/pcpu_pkg.sv | 19 +
 rtl/btb_table.sv | 58 +++++
 rtl/next_pc_ctrl.sv | 135 +++++++++++++
 tb/tb_next_pc_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcpu_pkg.sv
// rtl/pcpu_pkg.sv - shared types and constants for the next-PC controller and its BTB
package pcpu_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } pc_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Tag is stored zero-extended in the widest form (1-entry table); narrower tables leave the top bits zero.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
   } btb_entry_t;

endpackage

// File: rtl/btb_table.sv
// rtl/btb_table.sv - direct-mapped branch target buffer, combinational lookup, registered update
module btb_table #(
   parameter int ENTRIES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] lookup_pc,
   output logic        hit,
   output logic [31:0] hit_target,
   input  logic        upd_valid,
   input  logic        upd_taken,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target
);
   import pcpu_pkg::*;

   localparam int IDX_W = $clog2(ENTRIES);

   btb_entry_t       table_q [ENTRIES];
   btb_entry_t       table_d [ENTRIES];
   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] up_idx;
   logic [29:0]      lk_tag;
   logic [29:0]      up_tag;
   logic             unused_lsbs;

   assign lk_idx      = lookup_pc[IDX_W+1:2];
   assign up_idx      = upd_pc[IDX_W+1:2];
   assign lk_tag      = 30'(lookup_pc >> (IDX_W + 2));
   assign up_tag      = 30'(upd_pc >> (IDX_W + 2));
   assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

   // Lookup reads the pre-update contents; a same-index update lands for the next cycle.
   assign hit        = table_q[lk_idx].valid && (table_q[lk_idx].tag == lk_tag);
   assign hit_target = table_q[lk_idx].target;

   always_comb begin
      table_d = table_q;
      if (upd_valid && upd_taken) begin
         table_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: upd_target};
      end else if (upd_valid && !upd_taken && upd_pred_taken &&
                   table_q[up_idx].valid && (table_q[up_idx].tag == up_tag)) begin
         table_d[up_idx].valid = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '0;
         end
      end else begin
         table_q <= table_d;
      end
   end

endmodule

// File: rtl/next_pc_ctrl.sv
// rtl/next_pc_ctrl.sv - next-PC arbitration (mispredict > jump > stall > sequential) with IF/ID flushes
// Optional branch target buffer enabled by defining BTB_EN.
module next_pc_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h00000000,
   parameter int          BTB_ENTRIES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_target,
   input  logic        br_pred_taken,
   output logic [31:0] next_pc,
   output logic        pc_write,
   output logic        pred_taken,
   output logic        flush_if,
   output logic        flush_id
);
   import pcpu_pkg::*;

   pc_state_e   state_q, state_d;
   logic [31:0] next_pc_q, next_pc_d;
   logic        pc_write_q, pc_write_d;
   logic        pred_taken_q, pred_taken_d;
   logic        flush_if_q, flush_if_d;
   logic        flush_id_q, flush_id_d;

   logic        btb_hit;
   logic [31:0] btb_target;
   logic        eff_pred;
   logic        mispredict;
   logic [31:0] redirect_pc;

`ifdef BTB_EN
   btb_table #(
      .ENTRIES(BTB_ENTRIES)
   ) u_btb (
      .clk            (clk),
      .reset          (reset),
      .lookup_pc      (pc),
      .hit            (btb_hit),
      .hit_target     (btb_target),
      .upd_valid      (br_valid),
      .upd_taken      (br_taken),
      .upd_pred_taken (br_pred_taken),
      .upd_pc         (br_pc),
      .upd_target     (br_target)
   );
   assign eff_pred = br_pred_taken;
`else
   // Without a BTB every fetch is predicted not-taken, so the carried prediction is meaningless.
   localparam int unused_btb_entries = BTB_ENTRIES;
   logic unused_pred;
   assign unused_pred = br_pred_taken;
   assign btb_hit     = 1'b0;
   assign btb_target  = 32'h0;
   assign eff_pred    = 1'b0;
`endif

   assign mispredict  = br_valid && (br_taken != eff_pred);
   assign redirect_pc = br_taken ? br_target : br_pc + PC_STEP;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= BOOT;
         next_pc_q    <= RESET_PC;
         pc_write_q   <= 1'b0;
         pred_taken_q <= 1'b0;
         flush_if_q   <= 1'b0;
         flush_id_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         next_pc_q    <= next_pc_d;
         pc_write_q   <= pc_write_d;
         pred_taken_q <= pred_taken_d;
         flush_if_q   <= flush_if_d;
         flush_id_q   <= flush_id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         default: begin
            if (mispredict || jump) state_d = RUN;
            else if (stall)         state_d = STALL;
            else                    state_d = RUN;
         end
      endcase
   end

   // A mispredict outranks stall: the stalled instructions are on the squashed path.
   always_comb begin
      next_pc_d    = next_pc_q;
      pc_write_d   = 1'b0;
      pred_taken_d = 1'b0;
      flush_if_d   = 1'b0;
      flush_id_d   = 1'b0;
      case (state_q)
         BOOT: begin
            next_pc_d  = RESET_PC;
            pc_write_d = 1'b1;
         end
         default: begin
            if (mispredict) begin
               next_pc_d  = redirect_pc;
               pc_write_d = 1'b1;
               flush_if_d = 1'b1;
               flush_id_d = 1'b1;
            end else if (jump) begin
               next_pc_d  = jump_target;
               pc_write_d = 1'b1;
               flush_if_d = 1'b1;
            end else if (!stall) begin
               next_pc_d    = btb_hit ? btb_target : pc + PC_STEP;
               pc_write_d   = 1'b1;
               pred_taken_d = btb_hit;
            end
         end
      endcase
   end

   assign next_pc    = next_pc_q;
   assign pc_write   = pc_write_q;
   assign pred_taken = pred_taken_q;
   assign flush_if   = flush_if_q;
   assign flush_id   = flush_id_q;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// tb/tb_next_pc_ctrl.sv - directed self-checking bench for next_pc_ctrl with a behavioural PC register
module tb_next_pc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc;
   logic        stall = 1'b0;
   logic        jump = 1'b0;
   logic [31:0] jump_target = 32'h0;
   logic        br_valid = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_pc = 32'h0;
   logic [31:0] br_target = 32'h0;
   logic        br_pred_taken = 1'b0;
   logic [31:0] next_pc;
   logic        pc_write;
   logic        pred_taken;
   logic        flush_if;
   logic        flush_id;

   int checks = 0;
   int errors = 0;

   next_pc_ctrl #(
      .RESET_PC    (32'h00000000),
      .BTB_ENTRIES (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .br_valid      (br_valid),
      .br_taken      (br_taken),
      .br_pc         (br_pc),
      .br_target     (br_target),
      .br_pred_taken (br_pred_taken),
      .next_pc       (next_pc),
      .pc_write      (pc_write),
      .pred_taken    (pred_taken),
      .flush_if      (flush_if),
      .flush_id      (flush_id)
   );

   always #5 clk = ~clk;

   // PC register: captures on negedge, resets to one step before RESET_PC.
   always @(negedge clk or posedge reset) begin
      if (reset)         pc <= 32'hfffffffc;
      else if (pc_write) pc <= next_pc;
   end

   wire [35:0] obs = {next_pc, pc_write, pred_taken, flush_if, flush_id};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 1'b0; jump = 1'b0; jump_target = 32'h0;
      br_valid = 1'b0; br_taken = 1'b0; br_pc = 32'h0; br_target = 32'h0; br_pred_taken = 1'b0;
   endtask

   task automatic advance_to(input logic [31:0] a);
      int n;
      n = 0;
      while (pc !== a && n < 64) begin
         tick();
         settle();
         n++;
      end
      checks++;
      if (pc !== a) begin
         errors++;
         $display("FAIL advance_to got pc=%h want %h", pc, a);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (obs !== {32'h0, 4'b0000}) begin errors++; $display("FAIL reset_values got %h want %h", obs, {32'h0, 4'b0000}); end
      @(negedge clk); #1;
      reset = 1'b0;
      tick();
      checks++;
      if (obs !== {32'h0, 4'b1000}) begin errors++; $display("FAIL boot_fetch got %h want %h", obs, {32'h0, 4'b1000}); end
      settle();
      checks++;
      if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc got %h want %h", pc, 32'h0); end
      tick();
      checks++;
      if (obs !== {32'h4, 4'b1000}) begin errors++; $display("FAIL seq_4 got %h want %h", obs, {32'h4, 4'b1000}); end
      settle();
      tick();
      checks++;
      if (obs !== {32'h8, 4'b1000}) begin errors++; $display("FAIL seq_8 got %h want %h", obs, {32'h8, 4'b1000}); end
      settle();
   endtask

   task automatic test_stall();
      advance_to(32'h20);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (obs !== {32'h20, 4'b0000}) begin errors++; $display("FAIL stall_hold[%0d] got %h want %h", i, obs, {32'h20, 4'b0000}); end
         settle();
      end
      stall = 1'b0;
      tick();
      checks++;
      if (obs !== {32'h24, 4'b1000}) begin errors++; $display("FAIL stall_resume got %h want %h", obs, {32'h24, 4'b1000}); end
      settle();
   endtask

   task automatic test_jump();
      advance_to(32'h40);
      jump = 1'b1; jump_target = 32'h100;
      tick();
      checks++;
      if (obs !== {32'h100, 4'b1010}) begin errors++; $display("FAIL jump_redirect got %h want %h", obs, {32'h100, 4'b1010}); end
      settle();
      clear_inputs();
      tick();
      checks++;
      if (obs !== {32'h104, 4'b1000}) begin errors++; $display("FAIL jump_pulse_end got %h want %h", obs, {32'h104, 4'b1000}); end
      settle();
   endtask

   task automatic test_mispredict_priority();
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h200; br_pc = 32'h50; br_pred_taken = 1'b0;
      jump = 1'b1; jump_target = 32'h300; stall = 1'b1;
      tick();
      checks++;
      if (obs !== {32'h200, 4'b1011}) begin errors++; $display("FAIL mispredict_prio got %h want %h", obs, {32'h200, 4'b1011}); end
      settle();
      clear_inputs();
      tick();
      checks++;
      if (obs !== {32'h204, 4'b1000}) begin errors++; $display("FAIL mispredict_pulse_end got %h want %h", obs, {32'h204, 4'b1000}); end
      settle();
   endtask

   task automatic test_wrap();
      jump = 1'b1; jump_target = 32'hfffffffc;
      tick();
      settle();
      clear_inputs();
      checks++;
      if (pc !== 32'hfffffffc) begin errors++; $display("FAIL wrap_setup got pc=%h want %h", pc, 32'hfffffffc); end
      tick();
      checks++;
      if (obs !== {32'h0, 4'b1000}) begin errors++; $display("FAIL wrap_seq got %h want %h", obs, {32'h0, 4'b1000}); end
      settle();
   endtask

   task automatic test_not_taken_pred();
      logic [35:0] exp;
`ifdef BTB_EN
      exp = {32'h64, 4'b1011};
`else
      exp = {32'h4, 4'b1000};
`endif
      br_valid = 1'b1; br_taken = 1'b0; br_pred_taken = 1'b1; br_pc = 32'h60; br_target = 32'h400;
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL not_taken_pred got %h want %h", obs, exp); end
      settle();
      clear_inputs();
   endtask

`ifdef BTB_EN
   task automatic test_btb();
      jump = 1'b1; jump_target = 32'h30;
      tick(); settle(); clear_inputs();
      br_valid = 1'b1; br_taken = 1'b1; br_pc = 32'h30; br_target = 32'h80;
      tick();
      checks++;
      if (obs !== {32'h80, 4'b1011}) begin errors++; $display("FAIL btb_train got %h want %h", obs, {32'h80, 4'b1011}); end
      settle(); clear_inputs();
      jump = 1'b1; jump_target = 32'h30;
      tick(); settle(); clear_inputs();
      tick();
      checks++;
      if (obs !== {32'h80, 4'b1100}) begin errors++; $display("FAIL btb_hit got %h want %h", obs, {32'h80, 4'b1100}); end
      settle();
      br_valid = 1'b1; br_taken = 1'b0; br_pred_taken = 1'b1; br_pc = 32'h30; br_target = 32'h80;
      tick();
      checks++;
      if (obs !== {32'h34, 4'b1011}) begin errors++; $display("FAIL btb_mispredict got %h want %h", obs, {32'h34, 4'b1011}); end
      settle(); clear_inputs();
      jump = 1'b1; jump_target = 32'h30;
      tick(); settle(); clear_inputs();
      tick();
      checks++;
      if (obs !== {32'h34, 4'b1000}) begin errors++; $display("FAIL btb_invalidated got %h want %h", obs, {32'h34, 4'b1000}); end
      settle();
   endtask
`endif

   task automatic test_async_reset();
      stall = 1'b1;
      tick();
      checks++;
      if (pc_write !== 1'b0) begin errors++; $display("FAIL pre_reset_stall got pc_write=%b want 0", pc_write); end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== {32'h0, 4'b0000}) begin errors++; $display("FAIL async_reset got %h want %h", obs, {32'h0, 4'b0000}); end
      clear_inputs();
      settle();
      reset = 1'b0;
      tick();
      checks++;
      if (obs !== {32'h0, 4'b1000}) begin errors++; $display("FAIL reboot got %h want %h", obs, {32'h0, 4'b1000}); end
      settle();
   endtask

   initial begin
      test_reset();
      test_stall();
      test_jump();
      test_mispredict_priority();
      test_wrap();
      test_not_taken_pred();
`ifdef BTB_EN
      test_btb();
`endif
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

endmodule
